// File: rtl/apb2axi_rd_engine.sv
// apb2axi_rd_engine: multi-outstanding AXI3 read engine.
// Allocates ARIDs from a free pool, issues AR bursts back-to-back and checks/forwards R beats.
module apb2axi_rd_engine #(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_W    = 4,
    parameter int OUTSTANDING = 4,
    parameter int CNT_W       = $clog2(OUTSTANDING + 1)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic [2:0]            req_size,
    output logic [AXI_ID_W-1:0]   arid,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [AXI_ID_W-1:0]   rsp_id,
    output logic [AXI_DATA_W-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic [CNT_W-1:0]      outstanding_cnt,
    output logic                  idle
);

    function automatic logic [CNT_W-1:0] popcount(input logic [OUTSTANDING-1:0] vec);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            sum = sum + CNT_W'(vec[i]);
        end
        return sum;
    endfunction

    logic [OUTSTANDING-1:0] busy_r;
    logic [OUTSTANDING-1:0] busy_nxt_s;
    logic [3:0]             remaining_r     [OUTSTANDING];
    logic [3:0]             remaining_nxt_s [OUTSTANDING];
    logic [CNT_W-1:0]       cnt_r;

    logic                  arvalid_r;
    logic [AXI_ID_W-1:0]   arid_r;
    logic [AXI_ADDR_W-1:0] araddr_r;
    logic [3:0]            arlen_r;
    logic [2:0]            arsize_r;

    logic                  rsp_valid_r;
    logic [AXI_ID_W-1:0]   rsp_id_r;
    logic [AXI_DATA_W-1:0] rsp_data_r;
    logic [1:0]            rsp_resp_r;
    logic                  rsp_last_r;
    logic                  rsp_err_r;

    logic [AXI_ID_W-1:0] free_id_s;
    logic                any_free_s;
    logic                hit_busy_s;
    logic [3:0]          hit_rem_s;
    logic                req_fire_s;
    logic                r_fire_s;
    logic                rem_zero_s;
    logic                beat_err_s;
    logic                beat_free_s;
    logic                beat_dec_s;

    // Lowest-index free ID; scanning downward lets the lowest index win.
    always_comb begin
        free_id_s = '0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            free_id_s = busy_r[i] ? free_id_s : AXI_ID_W'(i);
        end
    end

    // Tracking state of the ID carried by the incoming R beat; out-of-pool IDs never hit.
    always_comb begin
        hit_busy_s = 1'b0;
        hit_rem_s  = 4'd0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            hit_busy_s = (rid == AXI_ID_W'(i)) ? busy_r[i]      : hit_busy_s;
            hit_rem_s  = (rid == AXI_ID_W'(i)) ? remaining_r[i] : hit_rem_s;
        end
    end

    assign any_free_s  = |(~busy_r);
    assign req_ready   = any_free_s & (~arvalid_r | arready);
    assign req_fire_s  = req_valid & req_ready;
    assign rready      = ~rsp_valid_r | rsp_ready;
    assign r_fire_s    = rvalid & rready;
    assign rem_zero_s  = (hit_rem_s == 4'd0);
    // rlast must coincide exactly with the final counted beat; any mismatch retires the ID.
    assign beat_err_s  = ~hit_busy_s | (rlast ^ rem_zero_s);
    assign beat_free_s = hit_busy_s & (rlast | rem_zero_s);
    assign beat_dec_s  = hit_busy_s & ~rlast & ~rem_zero_s;

    // Next busy bitmap and beat counters from allocation and beat retirement.
    always_comb begin
        busy_nxt_s      = busy_r;
        remaining_nxt_s = remaining_r;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (req_fire_s && (free_id_s == AXI_ID_W'(i))) begin
                busy_nxt_s[i]      = 1'b1;
                remaining_nxt_s[i] = req_len;
            end else if (r_fire_s && (rid == AXI_ID_W'(i)) && beat_free_s) begin
                busy_nxt_s[i] = 1'b0;
            end else if (r_fire_s && (rid == AXI_ID_W'(i)) && beat_dec_s) begin
                remaining_nxt_s[i] = remaining_r[i] - 4'd1;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Per-ID tracking registers and outstanding count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_r <= '0;
            cnt_r  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                remaining_r[i] <= 4'd0;
            end
        end else begin
            busy_r      <= busy_nxt_s;
            remaining_r <= remaining_nxt_s;
            cnt_r       <= popcount(busy_nxt_s);
        end
    end

    // AR channel: load on request handshake, drop valid once the slave accepts.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid_r <= 1'b0;
            arid_r    <= '0;
            araddr_r  <= '0;
            arlen_r   <= 4'd0;
            arsize_r  <= 3'd0;
        end else if (req_fire_s) begin
            arvalid_r <= 1'b1;
            arid_r    <= free_id_s;
            araddr_r  <= req_addr;
            arlen_r   <= req_len;
            arsize_r  <= req_size;
        end else if (arready) begin
            arvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Response stage: one registered slot, fields held until the next accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= '0;
            rsp_resp_r  <= 2'd0;
            rsp_last_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (r_fire_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= rid;
            rsp_data_r  <= rdata;
            rsp_resp_r  <= rresp;
            rsp_last_r  <= rlast;
            rsp_err_r   <= beat_err_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign arvalid         = arvalid_r;
    assign arid            = arid_r;
    assign araddr          = araddr_r;
    assign arlen           = arlen_r;
    assign arsize          = arsize_r;
    assign arburst         = 2'b01;
    assign arlock          = 1'b0;
    assign arcache         = 4'd0;
    assign arprot          = 3'd0;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_id          = rsp_id_r;
    assign rsp_data        = rsp_data_r;
    assign rsp_resp        = rsp_resp_r;
    assign rsp_last        = rsp_last_r;
    assign rsp_err         = rsp_err_r;
    assign outstanding_cnt = cnt_r;
    assign idle            = ~(|busy_r) & ~arvalid_r;

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Bench for apb2axi_rd_engine: directed scenarios, an error vector table and a
// randomized slave run, all cross-checked every cycle against a transaction-level model.
module tb_apb2axi_rd_engine;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int OS = 4;
    localparam int CW = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_len;
    logic [2:0]    req_size;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          rsp_valid, rsp_ready;
    logic [IW-1:0] rsp_id;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_last, rsp_err;
    logic [CW-1:0] outstanding_cnt;
    logic          idle;

    apb2axi_rd_engine #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .OUTSTANDING(OS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .outstanding_cnt(outstanding_cnt), .idle(idle)
    );

    always #5 aclk = ~aclk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Transaction-level reference state: which IDs are in flight and how many beats remain.
    bit            m_busy [OS];
    int            m_rem  [OS];
    bit            m_arp;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [3:0]    m_arlen;
    logic [2:0]    m_arsize;
    bit            m_rspp;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    bit            m_rlast, m_rerr;
    bit            r_acc;

    // Slave side: bursts seen on AR, with beats still to deliver.
    int sl_id[$];
    int sl_left[$];
    int sel;

    typedef struct {
        bit         do_req;
        logic [3:0] len;
        logic [3:0] rid;
        bit         rlast;
        logic [1:0] rresp;
        bit         exp_err;
        int         exp_cnt;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < OS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < OS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < OS; i++) begin m_busy[i] = 0; m_rem[i] = 0; end
        m_arp = 0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
        m_rspp = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rerr = 0;
        sl_id.delete(); sl_left.delete();
    endtask

    task automatic check_outputs();
        chk("arvalid", arvalid, m_arp);
        chk("arid", arid, m_arid);
        chk("araddr", araddr, m_araddr);
        chk("arlen", arlen, m_arlen);
        chk("arsize", arsize, m_arsize);
        chk("arburst", arburst, 2'b01);
        chk("ar_const", {arlock, arcache, arprot}, 8'h00);
        chk("req_ready", req_ready, (lowest_free() >= 0) && (!m_arp || arready));
        chk("rready", rready, !m_rspp || rsp_ready);
        chk("rsp_valid", rsp_valid, m_rspp);
        chk("rsp_id", rsp_id, m_rid);
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_resp", rsp_resp, m_rresp);
        chk("rsp_last", rsp_last, m_rlast);
        chk("rsp_err", rsp_err, m_rerr);
        chk("outstanding_cnt", outstanding_cnt, busy_count());
        chk("idle", idle, (busy_count() == 0) && !m_arp);
    endtask

    // Apply one clock edge's worth of protocol rules to the model.
    task automatic model_update();
        int lf, k, clr;
        bit req_rdy;
        r_acc = 0;
        if (!aresetn) begin model_reset(); return; end
        lf = lowest_free();
        req_rdy = (lf >= 0) && (!m_arp || arready);
        r_acc = rvalid && (!m_rspp || rsp_ready);
        clr = -1;
        if (r_acc) begin
            k = int'(rid);
            m_rspp = 1; m_rid = rid; m_rdata = rdata; m_rresp = rresp; m_rlast = rlast;
            if (k >= OS || !m_busy[k]) m_rerr = 1;
            else if (rlast != (m_rem[k] == 0)) begin m_rerr = 1; clr = k; end
            else begin
                m_rerr = 0;
                if (rlast) clr = k;
                else m_rem[k]--;
            end
        end else if (rsp_ready) m_rspp = 0;
        if (m_arp && arready) begin sl_id.push_back(int'(m_arid)); sl_left.push_back(int'(m_arlen) + 1); end
        if (req_valid && req_rdy) begin
            m_arp = 1; m_arid = IW'(lf); m_araddr = req_addr; m_arlen = req_len; m_arsize = req_size;
            m_busy[lf] = 1; m_rem[lf] = int'(req_len);
        end else if (arready) m_arp = 0;
        if (clr >= 0) m_busy[clr] = 0;
    endtask

    task automatic cycle();
        @(negedge aclk);
        check_outputs();
        model_update();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input int id, input bit last, input logic [DW-1:0] d);
        rvalid = 1; rid = IW'(id); rlast = last; rdata = d; rresp = 2'd0;
    endtask

    task automatic slave_drive();
        if (!rvalid && sl_id.size() > 0 && ($urandom % 3) != 0) begin
            sel = $urandom_range(0, sl_id.size() - 1);
            rvalid = 1; rid = IW'(sl_id[sel]); rlast = (sl_left[sel] == 1);
            rdata = {$urandom, $urandom}; rresp = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic slave_retire();
        if (r_acc) begin
            sl_left[sel]--;
            if (sl_left[sel] == 0) begin sl_id.delete(sel); sl_left.delete(sel); end
            rvalid = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 0; req_valid = 0; req_addr = '0; req_len = '0; req_size = '0; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rsp_ready = 1;
        model_reset();
        @(posedge aclk); #1;
        cycle(); cycle();
        aresetn = 1;
        cycle();
        chk("rst_idle", idle, 1'b1);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_cnt", outstanding_cnt, 3'd0);

        // Single read of four beats.
        req_valid = 1; req_addr = 32'h1000; req_len = 4'd3; req_size = 3'd3;
        cycle();
        chk("single_arvalid", arvalid, 1'b1);
        chk("single_arid", arid, 4'd0);
        chk("single_araddr", araddr, 32'h1000);
        chk("single_arlen", arlen, 4'd3);
        req_valid = 0; arready = 1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            beat(0, i == 3, 64'hD000 + 64'(i));
            cycle();
            chk("single_rsp_data", rsp_data, 64'hD000 + 64'(i));
            chk("single_rsp_err", rsp_err, 1'b0);
        end
        rvalid = 0; #1;
        chk("single_idle_after", idle, 1'b1);
        cycle();

        // Fill the pool, then a freed ID is reused.
        req_valid = 1; req_len = 4'd0; req_size = 3'd2;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h100 * 32'(i);
            cycle();
            chk("fill_arid", arid, 4'(i));
        end
        req_addr = 32'h500; #1;
        chk("fill_req_ready_full", req_ready, 1'b0);
        beat(2, 1, 64'h22);
        cycle();
        rvalid = 0; #1;
        chk("fill_req_ready_freed", req_ready, 1'b1);
        cycle();
        chk("fill_reuse_arid", arid, 4'd2);
        req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            beat((i == 2) ? 3 : ((i == 3) ? 2 : i), 1, 64'h30 + 64'(i));
            cycle();
        end
        rvalid = 0;
        cycle();
        chk("fill_drained_cnt", outstanding_cnt, 3'd0);

        // Out-of-order interleaving of two 2-beat bursts.
        req_valid = 1; req_len = 4'd1;
        cycle(); cycle();
        req_valid = 0;
        cycle();
        chk("ooo_cnt_2", outstanding_cnt, 3'd2);
        for (int i = 0; i < 4; i++) begin
            beat((i % 2 == 0) ? 1 : 0, i >= 2, 64'h40 + 64'(i));
            cycle();
            chk("ooo_rsp_id", rsp_id, (i % 2 == 0) ? 4'd1 : 4'd0);
            chk("ooo_rsp_err", rsp_err, 1'b0);
        end
        rvalid = 0;
        chk("ooo_cnt_0", outstanding_cnt, 3'd0);
        cycle();

        // Protocol-error vector table.
        tbl[0] = '{1, 4'd3, 4'd0, 0, 2'd0, 0, 1};
        tbl[1] = '{0, 4'd0, 4'd3, 0, 2'd0, 1, 1};
        tbl[2] = '{0, 4'd0, 4'd0, 0, 2'd0, 0, 1};
        tbl[3] = '{0, 4'd0, 4'd0, 1, 2'd0, 1, 0};
        tbl[4] = '{1, 4'd1, 4'd0, 0, 2'd0, 0, 1};
        tbl[5] = '{0, 4'd0, 4'd0, 0, 2'd0, 0, 1};
        tbl[6] = '{0, 4'd0, 4'd0, 0, 2'd0, 1, 0};
        tbl[7] = '{0, 4'd0, 4'd9, 1, 2'd0, 1, 0};
        tbl[8] = '{1, 4'd0, 4'd0, 0, 2'd0, 0, 1};
        tbl[9] = '{0, 4'd0, 4'd0, 1, 2'd2, 0, 0};
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].do_req; req_len = tbl[i].len; req_addr = 32'h2000 + 32'(i);
            rvalid = !tbl[i].do_req; rid = tbl[i].rid; rlast = tbl[i].rlast;
            rresp = tbl[i].rresp; rdata = 64'h5000 + 64'(i);
            cycle();
            chk("tbl_cnt", outstanding_cnt, CW'(tbl[i].exp_cnt));
            if (tbl[i].do_req) chk("tbl_arvalid", arvalid, 1'b1);
            else begin
                chk("tbl_rsp_valid", rsp_valid, 1'b1);
                chk("tbl_rsp_err", rsp_err, tbl[i].exp_err);
                chk("tbl_rsp_resp", rsp_resp, tbl[i].rresp);
            end
        end
        req_valid = 0; rvalid = 0;
        cycle();

        // Backpressure: response stalled for five cycles mid-burst.
        req_valid = 1; req_len = 4'd7;
        cycle();
        req_valid = 0;
        beat(0, 0, 64'hB0);
        cycle();
        rsp_ready = 0;
        beat(0, 0, 64'hB1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rready", rready, 1'b0);
            cycle();
            chk("bp_rsp_hold", rsp_data, 64'hB0);
        end
        rsp_ready = 1;
        for (int i = 1; i < 8; i++) begin
            beat(0, i == 7, 64'hB0 + 64'(i));
            cycle();
            chk("bp_rsp_data", rsp_data, 64'hB0 + 64'(i));
        end
        rvalid = 0;
        cycle();

        // Reset with two bursts outstanding.
        req_valid = 1; req_len = 4'd3;
        cycle(); cycle();
        req_valid = 0;
        beat(0, 0, 64'hC0);
        cycle();
        rvalid = 0;
        chk("mid_cnt_2", outstanding_cnt, 3'd2);
        aresetn = 0; #1;
        model_reset();
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_cnt", outstanding_cnt, 3'd0);
        chk("mid_rst_idle", idle, 1'b1);
        cycle();
        aresetn = 1;
        beat(1, 0, 64'hC1);
        cycle();
        rvalid = 0;
        chk("post_rst_err", rsp_err, 1'b1);
        req_valid = 1; req_len = 4'd0;
        cycle();
        req_valid = 0;
        chk("post_rst_arid", arid, 4'd0);

        // Randomized traffic against the model.
        aresetn = 0; model_reset();
        cycle();
        aresetn = 1;
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom % 3) == 0;
            req_addr = $urandom;
            req_len = 4'($urandom_range(0, 3));
            req_size = 3'($urandom_range(0, 3));
            arready = ($urandom % 4) != 0;
            rsp_ready = ($urandom % 4) != 0;
            slave_drive();
            cycle();
            slave_retire();
        end
        req_valid = 0; arready = 1; rsp_ready = 1;
        for (int c = 0; c < 1000 && (sl_id.size() != 0 || m_arp || m_rspp || rvalid); c++) begin
            slave_drive();
            cycle();
            slave_retire();
        end
        chk("final_idle", idle, 1'b1);
        chk("final_cnt", outstanding_cnt, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
